// File: rtl/rcb_wheel_pkg.sv
// Shared op/err codes, state encoding and pin bit maps for the wheel driver sequencer.
package rcb_wheel_pkg;

  localparam logic [1:0] OP_MOVE  = 2'd0;
  localparam logic [1:0] OP_HOME  = 2'd1;
  localparam logic [1:0] OP_RESET = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_ACK_TO   = 3'd1;
  localparam logic [2:0] ERR_DONE_TO  = 3'd2;
  localparam logic [2:0] ERR_FAULT    = 3'd3;
  localparam logic [2:0] ERR_ABORTED  = 3'd4;
  localparam logic [2:0] ERR_REJECTED = 3'd5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_STROBE    = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RST_PULSE = 3'd4;
  localparam logic [2:0] ST_ABORT     = 3'd5;
  localparam logic [2:0] ST_FAULT     = 3'd6;

  localparam int unsigned DO_ACK    = 0;
  localparam int unsigned DO_MOVING = 1;
  localparam int unsigned DO_DONE   = 2;
  localparam int unsigned DO_FAULT  = 3;
  localparam int unsigned DO_W      = 4;

  localparam int unsigned DI_STROBE = 7;
  localparam int unsigned DI_HOME   = 6;
  localparam int unsigned DI_W      = 8;
  localparam int unsigned PAY_W     = 6;

  localparam int unsigned US_W = 20;

  // Assemble a DI pin word from its fields.
  function automatic logic [DI_W-1:0] di_word(input logic strobe, input logic home,
                                              input logic [PAY_W-1:0] pay);
    logic [DI_W-1:0] w;
    w = '0;
    w[PAY_W-1:0] = pay;
    w[DI_HOME]   = home;
    w[DI_STROBE] = strobe;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, synchronous active-low clear.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/wheel_drv_seq.sv
// Command sequencer for one wheel driver: DI setup/strobe, ack/done waits with
// timeouts, timed reset/abort pulses and completion status back to the registers.
module wheel_drv_seq
  import rcb_wheel_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned SETUP_CYC  = 10,
  parameter int unsigned ACK_TO_US  = 1000,
  parameter int unsigned DONE_TO_US = 500000,
  parameter int unsigned RST_US     = 10,
  parameter int unsigned ABRT_US    = 10
) (
  input  logic       clk_100m,
  input  logic       rst_n_syn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [6:0] cmd_data,
  input  logic       abort_req,
  input  logic [3:0] wheel_driver_do,
  output logic [7:0] wheel_driver_di,
  output logic       wheel_driver_rst,
  output logic       wheel_driver_abrt,
  output logic       busy,
  output logic       done,
  output logic [2:0] err
);

  localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned CYC_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  // Last µs index of each timed state; DONE_TO_US must fit in the 20-bit counter.
  localparam logic [US_W-1:0]  ACK_LAST  = US_W'(ACK_TO_US - 1);
  localparam logic [US_W-1:0]  DONE_LAST = US_W'(DONE_TO_US - 1);
  localparam logic [US_W-1:0]  RST_LAST  = US_W'(RST_US - 1);
  localparam logic [US_W-1:0]  ABRT_LAST = US_W'(ABRT_US - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(SETUP_CYC - 1);

  logic [2:0]       r_state;
  logic             r_home;
  logic [PAY_W-1:0] r_data;
  logic [PRE_W-1:0] r_pre;
  logic [US_W-1:0]  r_us;
  logic [CYC_W-1:0] r_cyc;
  logic             r_cmd_ready;
  logic [DI_W-1:0]  r_di;
  logic             r_rst;
  logic             r_abrt;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_err;

  logic [DO_W-1:0]  w_do;
  logic             w_tick;
  logic             w_accept;
  logic             w_home_nx;
  logic [PAY_W-1:0] w_data_nx;
  logic [2:0]       w_next;
  logic [2:0]       w_err_nx;
  logic             w_done_nx;
  logic [DI_W-1:0]  w_di_nx;
  logic             w_busy_nx;
  logic             w_ready_nx;
  logic             w_unused;

  sync_2ff #(.WIDTH(DO_W)) u_do_sync (
    .i_clk   (clk_100m),
    .i_rst_n (rst_n_syn),
    .i_d     (wheel_driver_do),
    .o_q     (w_do)
  );

  assign w_unused  = ^{cmd_data[6], w_do[DO_MOVING]};
  assign w_tick    = (r_pre == PRE_LAST);
  assign w_accept  = cmd_valid & r_cmd_ready & ~abort_req;
  assign w_home_nx = w_accept ? (cmd_op == OP_HOME) : r_home;
  assign w_data_nx = w_accept ? cmd_data[PAY_W-1:0] : r_data;

  // Next state, status and registered-output values; abort > fault > ack/done > timeout.
  always_comb begin
    w_next    = r_state;
    w_err_nx  = r_err;
    w_done_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (abort_req) begin
          w_next = ST_ABORT;
        end else if (w_accept) begin
          w_err_nx = ERR_OK;
          case (cmd_op)
            OP_MOVE, OP_HOME: w_next = ST_SETUP;
            OP_RESET:         w_next = ST_RST_PULSE;
            default:          w_done_nx = 1'b1;
          endcase
        end
      end
      ST_SETUP: begin
        if (abort_req)             w_next = ST_ABORT;
        else if (r_cyc == CYC_LAST) w_next = ST_STROBE;
      end
      ST_STROBE: begin
        if (abort_req) begin
          w_next = ST_ABORT;
        end else if (w_do[DO_FAULT]) begin
          w_next = ST_FAULT;  w_err_nx = ERR_FAULT;   w_done_nx = 1'b1;
        end else if (w_do[DO_ACK]) begin
          w_next = ST_WAIT_DONE;
        end else if (w_tick && r_us == ACK_LAST) begin
          w_next = ST_IDLE;   w_err_nx = ERR_ACK_TO;  w_done_nx = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (abort_req) begin
          w_next = ST_ABORT;
        end else if (w_do[DO_FAULT]) begin
          w_next = ST_FAULT;  w_err_nx = ERR_FAULT;   w_done_nx = 1'b1;
        end else if (w_do[DO_DONE]) begin
          w_next = ST_IDLE;   w_err_nx = ERR_OK;      w_done_nx = 1'b1;
        end else if (w_tick && r_us == DONE_LAST) begin
          w_next = ST_IDLE;   w_err_nx = ERR_DONE_TO; w_done_nx = 1'b1;
        end
      end
      ST_RST_PULSE: begin
        if (abort_req) begin
          w_next = ST_ABORT;
        end else if (w_tick && r_us == RST_LAST) begin
          w_next = ST_IDLE;   w_err_nx = ERR_OK;      w_done_nx = 1'b1;
        end
      end
      ST_ABORT: begin
        // A held abort level re-enters through IDLE once this pulse completes.
        if (w_tick && r_us == ABRT_LAST) begin
          w_next = ST_IDLE;   w_err_nx = ERR_ABORTED; w_done_nx = 1'b1;
        end
      end
      ST_FAULT: begin
        if (abort_req) begin
          w_next = ST_ABORT;
        end else if (w_accept) begin
          if (cmd_op == OP_RESET) begin
            w_next = ST_RST_PULSE; w_err_nx = ERR_OK;
          end else begin
            w_err_nx = ERR_REJECTED; w_done_nx = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase

    w_di_nx = '0;
    case (w_next)
      ST_SETUP, ST_WAIT_DONE: w_di_nx = di_word(1'b0, w_home_nx, w_data_nx);
      ST_STROBE:              w_di_nx = di_word(1'b1, w_home_nx, w_data_nx);
      default:                w_di_nx = '0;
    endcase

    w_busy_nx  = !(w_next == ST_IDLE || w_next == ST_FAULT);
    w_ready_nx = !w_busy_nx && !w_accept;
  end

  always_ff @(posedge clk_100m) begin
    if (!rst_n_syn) begin
      r_state     <= ST_IDLE;
      r_home      <= 1'b0;
      r_data      <= '0;
      r_pre       <= '0;
      r_us        <= '0;
      r_cyc       <= '0;
      r_cmd_ready <= 1'b0;
      r_di        <= '0;
      r_rst       <= 1'b0;
      r_abrt      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= ERR_OK;
    end else begin
      r_state     <= w_next;
      r_home      <= w_home_nx;
      r_data      <= w_data_nx;
      r_cmd_ready <= w_ready_nx;
      r_di        <= w_di_nx;
      r_rst       <= (w_next == ST_RST_PULSE);
      r_abrt      <= (w_next == ST_ABORT);
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      // Prescaler and counters restart on every state entry; µs count saturates.
      if (w_next != r_state) begin
        r_pre <= '0;
        r_us  <= '0;
        r_cyc <= '0;
      end else begin
        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
        r_cyc <= r_cyc + CYC_W'(1);
        if (w_tick && r_us != '1) r_us <= r_us + US_W'(1);
      end
    end
  end

  assign cmd_ready         = r_cmd_ready;
  assign wheel_driver_di   = r_di;
  assign wheel_driver_rst  = r_rst;
  assign wheel_driver_abrt = r_abrt;
  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;

endmodule

// File: tb/tb_wheel_drv_seq.sv
// Bench for wheel_drv_seq: expected pin/status timelines are derived per cycle from
// the command rules (setup length, 2-cycle DO sync, µs timeouts) with plain arithmetic.
module tb_wheel_drv_seq;
  import rcb_wheel_pkg::*;

  localparam int CPU    = 4;
  localparam int SCYC   = 2;
  localparam int T_ACK  = 5 * CPU;
  localparam int T_DONE = 20 * CPU;
  localparam int T_RST  = 3 * CPU;
  localparam int T_ABRT = 2 * CPU;

  logic       clk_100m;
  logic       rst_n_syn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [6:0] cmd_data;
  logic       abort_req;
  logic [3:0] wheel_driver_do;
  logic [7:0] wheel_driver_di;
  logic       wheel_driver_rst;
  logic       wheel_driver_abrt;
  logic       busy;
  logic       done;
  logic [2:0] err;

  logic [15:0] obs;
  int          n_tests;
  int          n_fail;
  logic [2:0]  exp_err;

  wheel_drv_seq #(
    .CLK_PER_US(4), .SETUP_CYC(2), .ACK_TO_US(5), .DONE_TO_US(20), .RST_US(3), .ABRT_US(2)
  ) dut (
    .clk_100m          (clk_100m),
    .rst_n_syn         (rst_n_syn),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_data          (cmd_data),
    .abort_req         (abort_req),
    .wheel_driver_do   (wheel_driver_do),
    .wheel_driver_di   (wheel_driver_di),
    .wheel_driver_rst  (wheel_driver_rst),
    .wheel_driver_abrt (wheel_driver_abrt),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  initial clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  // Observed vector: {di[7:0], busy, ready, done, err[2:0], rst, abrt}
  assign obs = {wheel_driver_di, busy, cmd_ready, done, err, wheel_driver_rst, wheel_driver_abrt};

  function automatic logic [15:0] ev(input logic [7:0] di, input logic bsy, input logic rdy,
                                     input logic dn, input logic [2:0] er, input logic rs,
                                     input logic ab);
    return {di, bsy, rdy, dn, er, rs, ab};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk_100m);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL ready_wait cmd_ready=%b want 1 within 50 cycles", cmd_ready);
    end
  endtask

  // Present one command for a single accepting edge; returns at the first cycle after accept.
  task automatic issue(input logic [1:0] op, input logic [6:0] data);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(negedge clk_100m);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100m);
      n_tests++;
      if (obs !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, obs, 16'h0);
      end
    end
    rst_n_syn = 1'b1;
    @(negedge clk_100m);
    n_tests++;
    if (obs !== ev(8'h00, 0, 1, 0, ERR_OK, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", obs, ev(8'h00, 0, 1, 0, ERR_OK, 0, 0));
    end
  endtask

  // MOVE/HOME: ack_dly/done_dly are cycles after strobe/WAIT_DONE entry at which the pin rises (-1: never).
  task automatic test_move(input string name, input logic [1:0] op, input logic [6:0] data,
                           input int ack_dly, input int done_dly, input logic fault);
    int k0, w, x;
    logic [2:0] er;
    logic [7:0] pay;
    logic [15:0] e;
    pay = {1'b0, op == OP_HOME, data[5:0]};
    k0  = SCYC + 1;
    if (ack_dly >= 0 && ack_dly + 2 <= T_ACK - 1) begin
      w = k0 + ack_dly + 3;
      if (done_dly >= 0 && done_dly + 2 <= T_DONE - 1) begin
        x = w + done_dly + 3; er = fault ? ERR_FAULT : ERR_OK;
      end else begin
        x = w + T_DONE; er = ERR_DONE_TO;
      end
    end else begin
      w = -1; x = k0 + T_ACK; er = ERR_ACK_TO;
    end
    issue(op, data);
    for (int k = 1; k <= x + 1; k++) begin
      if (k < k0)                    e = ev(pay, 1, 0, 0, ERR_OK, 0, 0);
      else if (k < x && (w < 0 || k < w)) e = ev(pay | 8'h80, 1, 0, 0, ERR_OK, 0, 0);
      else if (k < x)                e = ev(pay, 1, 0, 0, ERR_OK, 0, 0);
      else if (k == x)               e = ev(8'h00, 0, 1, 1, er, 0, 0);
      else                           e = ev(8'h00, 0, 1, 0, er, 0, 0);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s k=%0d got=%h exp=%h", name, k, obs, e);
      end
      if (ack_dly >= 0 && k == k0 + ack_dly) wheel_driver_do[DO_ACK] = 1'b1;
      if (w >= 0 && done_dly >= 0 && k == w + done_dly) begin
        wheel_driver_do[DO_DONE] = 1'b1;
        if (fault) wheel_driver_do[DO_FAULT] = 1'b1;
      end
      if (k == x) wheel_driver_do = '0;
      @(negedge clk_100m);
    end
    exp_err = er;
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [6:0] data;
    int a, d;
    for (int i = 0; i < 12; i++) begin
      op   = 2'($urandom_range(0, 1));
      data = 7'($urandom);
      a    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 19));
      d    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 79));
      test_move("random", op, data, a, d, 1'b0);
    end
  endtask

  task automatic test_fault();
    test_move("fault_entry", OP_MOVE, 7'h11, 3, 10, 1'b1);
    issue(OP_MOVE, 7'h05);
    n_tests++;
    if (obs !== ev(8'h00, 0, 0, 1, ERR_REJECTED, 0, 0)) begin
      n_fail++;
      $display("FAIL fault_reject got=%h exp=%h", obs, ev(8'h00, 0, 0, 1, ERR_REJECTED, 0, 0));
    end
    @(negedge clk_100m);
    n_tests++;
    if (obs !== ev(8'h00, 0, 1, 0, ERR_REJECTED, 0, 0)) begin
      n_fail++;
      $display("FAIL fault_stay got=%h exp=%h", obs, ev(8'h00, 0, 1, 0, ERR_REJECTED, 0, 0));
    end
    issue(OP_RESET, 7'h00);
    for (int k = 1; k <= T_RST; k++) begin
      n_tests++;
      if (obs !== ev(8'h00, 1, 0, 0, ERR_OK, 1, 0)) begin
        n_fail++;
        $display("FAIL rst_pulse k=%0d got=%h exp=%h", k, obs, ev(8'h00, 1, 0, 0, ERR_OK, 1, 0));
      end
      @(negedge clk_100m);
    end
    n_tests++;
    if (obs !== ev(8'h00, 0, 1, 1, ERR_OK, 0, 0)) begin
      n_fail++;
      $display("FAIL rst_end got=%h exp=%h", obs, ev(8'h00, 0, 1, 1, ERR_OK, 0, 0));
    end
    exp_err = ERR_OK;
    @(negedge clk_100m);
  endtask

  // One-cycle abort at cycle at_k after a MOVE accept (ack given 2 cycles into strobe).
  task automatic test_abort(input int at_k);
    for (int k = 1; k < at_k; k++) begin
      if (k == 1) issue(OP_MOVE, 7'h2C);
      if (k == SCYC + 3) wheel_driver_do[DO_ACK] = 1'b1;
      if (k > 1 || at_k <= 1) @(negedge clk_100m);
    end
    if (at_k <= 1) issue(OP_MOVE, 7'h2C);
    abort_req = 1'b1;
    @(negedge clk_100m);
    abort_req = 1'b0;
    for (int k = 1; k <= T_ABRT; k++) begin
      n_tests++;
      if (obs !== ev(8'h00, 1, 0, 0, ERR_OK, 0, 1)) begin
        n_fail++;
        $display("FAIL abort_at%0d k=%0d got=%h exp=%h", at_k, k, obs, ev(8'h00, 1, 0, 0, ERR_OK, 0, 1));
      end
      @(negedge clk_100m);
    end
    n_tests++;
    if (obs !== ev(8'h00, 0, 1, 1, ERR_ABORTED, 0, 0)) begin
      n_fail++;
      $display("FAIL abort_at%0d_end got=%h exp=%h", at_k, obs, ev(8'h00, 0, 1, 1, ERR_ABORTED, 0, 0));
    end
    exp_err = ERR_ABORTED;
    wheel_driver_do = '0;
    @(negedge clk_100m);
  endtask

  task automatic test_abort_idle();
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_MOVE; cmd_data = 7'h3F; abort_req = 1'b1;
    @(negedge clk_100m);
    cmd_valid = 1'b0; abort_req = 1'b0;
    for (int k = 1; k <= T_ABRT; k++) begin
      n_tests++;
      if (obs !== ev(8'h00, 1, 0, 0, exp_err, 0, 1)) begin
        n_fail++;
        $display("FAIL abort_idle k=%0d got=%h exp=%h", k, obs, ev(8'h00, 1, 0, 0, exp_err, 0, 1));
      end
      @(negedge clk_100m);
    end
    n_tests++;
    if (obs !== ev(8'h00, 0, 1, 1, ERR_ABORTED, 0, 0)) begin
      n_fail++;
      $display("FAIL abort_idle_end got=%h exp=%h", obs, ev(8'h00, 0, 1, 1, ERR_ABORTED, 0, 0));
    end
    exp_err = ERR_ABORTED;
    @(negedge clk_100m);
    n_tests++;
    if (obs !== ev(8'h00, 0, 1, 0, ERR_ABORTED, 0, 0)) begin
      n_fail++;
      $display("FAIL abort_idle_after got=%h exp=%h", obs, ev(8'h00, 0, 1, 0, ERR_ABORTED, 0, 0));
    end
  endtask

  // Abort level held across the first pulse's completion triggers a second pulse.
  task automatic test_abort_level();
    logic [15:0] e;
    wait_ready();
    abort_req = 1'b1;
    for (int k = 1; k <= 2 * T_ABRT + 2; k++) begin
      @(negedge clk_100m);
      if (k <= T_ABRT)              e = ev(8'h00, 1, 0, 0, exp_err, 0, 1);
      else if (k == T_ABRT + 1)     e = ev(8'h00, 0, 1, 1, ERR_ABORTED, 0, 0);
      else if (k <= 2 * T_ABRT + 1) e = ev(8'h00, 1, 0, 0, ERR_ABORTED, 0, 1);
      else                          e = ev(8'h00, 0, 1, 1, ERR_ABORTED, 0, 0);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL abort_level k=%0d got=%h exp=%h", k, obs, e);
      end
      if (k == T_ABRT + 2) abort_req = 1'b0;
    end
    exp_err = ERR_ABORTED;
    @(negedge clk_100m);
  endtask

  task automatic test_reset_mid();
    issue(OP_MOVE, 7'h33);
    for (int k = 1; k < SCYC + 4; k++) @(negedge clk_100m);
    n_tests++;
    if (obs !== ev(8'hB3, 1, 0, 0, ERR_OK, 0, 0)) begin
      n_fail++;
      $display("FAIL rstmid_strobe got=%h exp=%h", obs, ev(8'hB3, 1, 0, 0, ERR_OK, 0, 0));
    end
    rst_n_syn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_100m);
      n_tests++;
      if (obs !== 16'h0) begin
        n_fail++;
        $display("FAIL rstmid_clear k=%0d got=%h exp=%h", k, obs, 16'h0);
      end
    end
    rst_n_syn = 1'b1;
    @(negedge clk_100m);
    n_tests++;
    if (obs !== ev(8'h00, 0, 1, 0, ERR_OK, 0, 0)) begin
      n_fail++;
      $display("FAIL rstmid_release got=%h exp=%h", obs, ev(8'h00, 0, 1, 0, ERR_OK, 0, 0));
    end
    exp_err = ERR_OK;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_NOP; cmd_data = 7'h00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_100m);
      e = (k % 2 == 1) ? ev(8'h00, 0, 0, 1, ERR_OK, 0, 0) : ev(8'h00, 0, 1, 0, ERR_OK, 0, 0);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL nop_b2b k=%0d got=%h exp=%h", k, obs, e);
      end
    end
    cmd_valid = 1'b0;
    exp_err = ERR_OK;
    @(negedge clk_100m);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_err = ERR_OK;
    rst_n_syn = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0;
    abort_req = 1'b0; wheel_driver_do = '0;

    test_reset();
    test_move("move_2a", OP_MOVE, 7'h2A, 6, 30, 1'b0);
    test_move("home_no_ack", OP_HOME, 7'h15, -1, -1, 1'b0);
    test_abort_idle();
    test_move("ack_last", OP_MOVE, 7'h07, 17, 5, 1'b0);
    test_move("ack_late", OP_HOME, 7'h38, 18, -1, 1'b0);
    test_move("done_last", OP_MOVE, 7'h19, 2, 77, 1'b0);
    test_move("done_late", OP_MOVE, 7'h26, 2, 78, 1'b0);
    test_random();
    test_fault();
    test_abort(1);
    test_abort(SCYC + 2);
    test_abort(12);
    test_abort_level();
    test_reset_mid();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
